// File: rtl/set_bit_serializer.sv
// Decomposes a WIDTH-bit mask into its set bits, emitting one bit index per
// valid/ready transfer, lowest index first.
module set_bit_serializer #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_last,
  output logic             empty_done
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] low, rest;
  logic [IDX_W-1:0] idx;
  logic             empty_n;
  logic             busy;

  // Two's-complement trick isolates the lowest set bit; rest drops it.
  assign low  = rem & (~rem + WIDTH'(1));
  assign rest = rem & (rem - WIDTH'(1));
  assign busy = (state == BUSY);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (low[i]) idx = idx | IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      empty_done <= 1'b0;
    end else begin
      state      <= state_n;
      rem        <= rem_n;
      empty_done <= empty_n;
    end
  end

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    empty_n   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_mask == '0) begin
            empty_n = 1'b1;
          end else begin
            rem_n   = in_mask;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rem_n = rest;
          if (rest == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are forced to zero outside BUSY so IDLE never shows stale data.
  assign out_onehot = busy ? low : '0;
  assign out_index  = busy ? idx : '0;
  assign out_last   = busy && (rest == '0);

endmodule
